// File: rtl/s3g_pkg.sv
// Shared S3G protocol definitions: framing constants, parser states and CRC-8.
// Used by both the packet receiver and the packet transmitter.
package s3g_pkg;

    localparam logic [7:0] S3G_START       = 8'hD5;
    localparam int         S3G_MAX_PAYLOAD = 15;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CRC
    } s3g_state_t;

    // CRC-8, polynomial x^8+x^2+x+1, MSB first, one byte per call.
    function automatic logic [7:0] nextCRC8_D8(
        input logic [7:0] data,
        input logic [7:0] crc
    );
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) c = {c[6:0], 1'b0} ^ 8'h07;
            else      c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/s3g_rx_if.sv
// Byte-stream input, consumer handshake and held-packet outputs of s3g_rx.
// The slave modport is the receiver; master is the byte source / consumer side.
interface s3g_rx_if;

    logic [7:0] rx_data;
    logic       rx_wr;
    logic       packet_ack;
    logic       packet_ready;
    logic [7:0] payload_len;
    logic [7:0] buf0;
    logic [7:0] buf1;
    logic [7:0] buf2;
    logic [7:0] buf3;
    logic [7:0] buf4;
    logic [7:0] buf5;
    logic [7:0] buf6;
    logic [7:0] buf7;
    logic [7:0] buf8;
    logic [7:0] buf9;
    logic [7:0] buf10;
    logic [7:0] buf11;
    logic [7:0] buf12;
    logic [7:0] buf13;
    logic [7:0] buf14;
    logic [7:0] buf15;
    logic       busy;
    logic       crc_error;
    logic       len_error;
    logic       overrun;
    logic       timeout;

    modport slave (
        input  rx_data, rx_wr, packet_ack,
        output packet_ready, payload_len,
        output buf0, buf1, buf2, buf3, buf4, buf5, buf6, buf7,
        output buf8, buf9, buf10, buf11, buf12, buf13, buf14, buf15,
        output busy, crc_error, len_error, overrun, timeout
    );

    modport master (
        output rx_data, rx_wr, packet_ack,
        input  packet_ready, payload_len,
        input  buf0, buf1, buf2, buf3, buf4, buf5, buf6, buf7,
        input  buf8, buf9, buf10, buf11, buf12, buf13, buf14, buf15,
        input  busy, crc_error, len_error, overrun, timeout
    );

endinterface

// File: rtl/s3g_rx.sv
// S3G packet receiver: frames D5/len/payload/CRC-8 and holds the last good payload.
// Define S3G_RX_TIMEOUT_EN to build the inter-byte timeout counter.
module s3g_rx
    import s3g_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    s3g_rx_if.slave    bus
);

    s3g_state_t state, state_d;

    logic [3:0] len_q;
    logic [3:0] cnt;
    logic [7:0] crc;
    logic [7:0] work [16];
    logic [7:0] obuf [16];
    logic [7:0] out_len;
    logic       ready_q;
    logic       crc_err_q, len_err_q, ovr_q;

    logic       start_len, take_data, accept;
    logic       crc_err_d, len_err_d, ovr_d;
    logic       expire;
    logic       busy;

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d   = state;
        start_len = 1'b0;
        take_data = 1'b0;
        accept    = 1'b0;
        crc_err_d = 1'b0;
        len_err_d = 1'b0;
        ovr_d     = 1'b0;
        if (bus.rx_wr) begin
            unique case (state)
                S_IDLE: begin
                    if (bus.rx_data == S3G_START) state_d = S_LEN;
                end
                S_LEN: begin
                    if (bus.rx_data > 8'(S3G_MAX_PAYLOAD)) begin
                        len_err_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        start_len = 1'b1;
                        state_d   = (bus.rx_data == 8'd0) ? S_CRC : S_DATA;
                    end
                end
                S_DATA: begin
                    take_data = 1'b1;
                    if (cnt == len_q - 4'd1) state_d = S_CRC;
                end
                S_CRC: begin
                    state_d = S_IDLE;
                    if (bus.rx_data != crc)                 crc_err_d = 1'b1;
                    else if (!ready_q || bus.packet_ack)    accept    = 1'b1;
                    else                                    ovr_d     = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (expire) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q     <= 4'd0;
            cnt       <= 4'd0;
            crc       <= 8'd0;
            work      <= '{default: 8'h00};
            obuf      <= '{default: 8'h00};
            out_len   <= 8'd0;
            ready_q   <= 1'b0;
            crc_err_q <= 1'b0;
            len_err_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            crc_err_q <= crc_err_d;
            len_err_q <= len_err_d;
            ovr_q     <= ovr_d;
            if (start_len) begin
                len_q <= bus.rx_data[3:0];
                cnt   <= 4'd0;
                crc   <= 8'd0;
                work  <= '{default: 8'h00};
            end
            if (take_data) begin
                work[cnt] <= bus.rx_data;
                crc       <= nextCRC8_D8(bus.rx_data, crc);
                cnt       <= cnt + 4'd1;
            end
            // An ack in the same cycle as a good CRC frees the slot for it.
            if (accept) begin
                obuf    <= work;
                out_len <= {4'd0, len_q};
                ready_q <= 1'b1;
            end else if (bus.packet_ack) begin
                ready_q <= 1'b0;
            end
        end
    end

`ifdef S3G_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmr;
    logic          to_q;

    assign expire = busy && (tmr == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tmr  <= '0;
            to_q <= 1'b0;
        end else begin
            to_q <= expire && !bus.rx_wr;
            if (bus.rx_wr || !busy || expire) tmr <= '0;
            else                              tmr <= tmr + 1'b1;
        end
    end

    assign bus.timeout = to_q;
`else
    logic unused_cfg;

    assign unused_cfg  = ^TIMEOUT_CYCLES;
    assign expire      = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    assign bus.busy         = busy;
    assign bus.packet_ready = ready_q;
    assign bus.payload_len  = out_len;
    assign bus.crc_error    = crc_err_q;
    assign bus.len_error    = len_err_q;
    assign bus.overrun      = ovr_q;

    assign bus.buf0  = obuf[0];
    assign bus.buf1  = obuf[1];
    assign bus.buf2  = obuf[2];
    assign bus.buf3  = obuf[3];
    assign bus.buf4  = obuf[4];
    assign bus.buf5  = obuf[5];
    assign bus.buf6  = obuf[6];
    assign bus.buf7  = obuf[7];
    assign bus.buf8  = obuf[8];
    assign bus.buf9  = obuf[9];
    assign bus.buf10 = obuf[10];
    assign bus.buf11 = obuf[11];
    assign bus.buf12 = obuf[12];
    assign bus.buf13 = obuf[13];
    assign bus.buf14 = obuf[14];
    assign bus.buf15 = obuf[15];

endmodule

// File: doc/s3g_rx.md
# s3g_rx

S3G packet receiver: parses the byte stream from the UART receiver into framed packets (start byte 0xD5, length, 0–15 payload bytes, CRC-8) and presents a validated payload to the command decoder. Payload is collected in a working buffer and copied to a stable output buffer only when the CRC matches. Output data and length use the same layout as the packet transmitter's inputs (`payload_len`, `buf0`..`buf15`), so a loopback or echo path needs no re-mapping.

## Interface
- `TIMEOUT_CYCLES`, default 100000: inter-byte timeout in clk cycles; used only when `S3G_RX_TIMEOUT_EN` is defined.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `rx_data`  in  8  received byte; valid only when `rx_wr`=1.
- `rx_wr`  in  1  one-cycle strobe per received byte.
- `packet_ack`  in  1  consumer has read the output buffer; clears `packet_ready`.
- `packet_ready`  out  1  level; the output buffer holds a valid packet.
- `payload_len`  out  8  payload length of the held packet, 0..15.
- `buf0`..`buf15`  out  8 each  held payload bytes; bytes at index ≥ `payload_len` are 0.
- `busy`  out  1  parser is mid-packet (state ≠ S_IDLE).
- `crc_error`  out  1  one-cycle pulse: received CRC mismatch.
- `len_error`  out  1  one-cycle pulse: length byte > 15.
- `overrun`  out  1  one-cycle pulse: good packet dropped because `packet_ready` was still high.
- `timeout`  out  1  one-cycle pulse: inter-byte timeout; tied 0 when the macro is absent.

## Operation
- States: S_IDLE, S_LEN, S_DATA, S_CRC. All transitions occur only on cycles with `rx_wr`=1, except timeout and reset.
- S_IDLE: byte 0xD5 → S_LEN. Any other byte is discarded.
- S_LEN: byte L. If L > 15, pulse `len_error` → S_IDLE. Otherwise latch L, set cnt=0, crc=0, clear the working buffer to 0, then go to S_DATA (L>0) or S_CRC (L=0).
- S_DATA: work[cnt] ← byte; crc ← nextCRC8_D8(byte, crc); cnt+1. When cnt = L−1 → S_CRC. A 0xD5 byte here is payload, not a start byte.
- S_CRC: byte compared with crc. On mismatch, pulse `crc_error`. On match with `packet_ready`=0, copy work→buf, L→`payload_len`, and set `packet_ready`. On match with `packet_ready`=1 (and no ack that cycle), pulse `overrun` and keep the old contents. In every case → S_IDLE.
- `packet_ready` clears on `packet_ack`. Output buffer is stable while `packet_ready`=1.
- CRC: the codebase's `nextCRC8_D8(data, crc)`, init 0x00, no final XOR. Identical to the transmit side.

## Timing
- Reset values: state S_IDLE; `packet_ready`, `busy`, and all pulse outputs 0; `payload_len` 0; buf0..15 0; cnt and crc 0.
- Byte strobe at cycle N → state/counter/CRC update visible at N+1.
- CRC byte at N → `packet_ready`, new `buf*`/`payload_len`, or an error pulse at N+1. Latency from CRC strobe to data is exactly 1 cycle.
- `packet_ack` at N → `packet_ready`=0 at N+1.
- `packet_ack` and a good CRC byte in the same cycle: ack takes priority, the new packet is accepted, `packet_ready` stays 1 with new contents, no `overrun`.
- Back-to-back `rx_wr` on consecutive cycles is supported; no minimum gap.
- `rst` mid-packet: parser returns to S_IDLE next cycle. Partial packet is discarded; the output buffer is cleared.
- `rx_wr` asserted during `rst` is ignored.

## Configuration
- `S3G_RX_TIMEOUT_EN` defined: a counter clears on every `rx_wr` and increments while `busy`.
  - On reaching `TIMEOUT_CYCLES` with no strobe: pulse `timeout` and return to S_IDLE; the partial packet is discarded.
  - A strobe on the expiry cycle wins: the byte is processed and there is no timeout.
- Macro absent: no counter is built; `timeout`=0. The parser waits indefinitely mid-packet.

## Structure
- Shared package `s3g_pkg`: `S3G_START` = 8'hD5, `S3G_MAX_PAYLOAD` = 15, the state encoding, and the `nextCRC8_D8` function. The transmitter uses the same package.
- No sub-module. The timeout counter and CRC are inline; the working and output buffers are plain register arrays.

## Test plan
- D5 03 11 22 33 + correct CRC → `packet_ready`=1 one cycle after the CRC strobe, `payload_len`=3, buf0..2 = 11/22/33, buf3 = 0.
- D5 00 00 → zero-length packet accepted, `payload_len`=0; CRC byte 0x00 is correct. A wrong CRC byte 0x5A → `crc_error` pulse, `packet_ready` stays 0.
- Garbage 00 FF then D5 10 → `len_error` pulse. A following valid D5 01 D5 + CRC → accepted with buf0 = D5.
- Two good packets without ack → second causes `overrun`, buffer keeps the first. Repeat with `packet_ack` on the second CRC-strobe cycle → second packet accepted, no `overrun`.
- Assert `rst` after D5 02 AA → `busy`=0 next cycle. A subsequent full packet is received correctly.
- With `S3G_RX_TIMEOUT_EN`, `TIMEOUT_CYCLES`=20: D5 02 AA then silence → `timeout` pulse, `busy`=0. Silence of 19 cycles then BB + CRC → packet accepted.
